// File: rtl/lc4_insn_fetch_unit.sv
// Instruction fetch requester for the LC4 dual instruction read port.
// Issues (PC, PC+1) pairs, tracks them across the memory latency and buffers returns for decode.
module lc4_insn_fetch_unit #(
    parameter int          MEM_LATENCY = 0,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] RESET_PC    = 16'h8200
) (
    input  logic        idclk,
    input  logic        rst,
    input  logic        gwe,
    output logic        i1re,
    output logic        i2re,
    output logic [15:0] i1addr,
    output logic [15:0] i2addr,
    input  logic [15:0] i1data,
    input  logic [15:0] i2data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pc,
    output logic [15:0] out_insn1,
    output logic [15:0] out_insn2
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 8;

    logic [15:0]   pc_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [15:0]   fifo_pc_r [FIFO_DEPTH];
    logic [15:0]   fifo_i1_r [FIFO_DEPTH];
    logic [15:0]   fifo_i2_r [FIFO_DEPTH];

    logic [CW-1:0] inflight_s;
    logic [CW-1:0] credit_s;
    logic          issue_s;
    logic          pop_s;
    logic          push_s;
    logic          ret_valid_s;
    logic [15:0]   ret_pc_s;

    // Credit check: buffered + in flight - leaving this cycle must leave room for one more pair.
    always_comb begin
        pop_s    = (count_r != '0) & out_ready & gwe & ~redirect_valid;
        credit_s = CW'(count_r) + inflight_s - CW'(pop_s);
        issue_s  = gwe & ~rst & ~redirect_valid & (credit_s < CW'(FIFO_DEPTH));
        push_s   = ret_valid_s & gwe & ~rst & ~redirect_valid;
    end

    generate
        if (MEM_LATENCY == 0) begin : g_direct
            assign ret_valid_s = issue_s;
            assign ret_pc_s    = pc_r;
            assign inflight_s  = '0;
        end else begin : g_tracker
            logic [MEM_LATENCY-1:0] trk_valid_r;
            logic [15:0]            trk_pc_r [MEM_LATENCY];

            // Valid bits follow each issued pair; a redirect kills everything still in memory.
            always_ff @(posedge idclk) begin
                if (rst) begin
                    trk_valid_r <= '0;
                end else if (gwe) begin
                    if (redirect_valid) begin
                        trk_valid_r <= '0;
                    end else begin
                        trk_valid_r <= (trk_valid_r << 1) | MEM_LATENCY'(issue_s);
                    end
                end
            end

            // PC tags travel alongside the valid bits.
            always_ff @(posedge idclk) begin
                if (gwe) begin
                    trk_pc_r[0] <= pc_r;
                    for (int k = 1; k < MEM_LATENCY; k++) begin
                        trk_pc_r[k] <= trk_pc_r[k-1];
                    end
                end
            end

            // Population count of outstanding requests.
            always_comb begin
                inflight_s = '0;
                for (int k = 0; k < MEM_LATENCY; k++) begin
                    inflight_s = inflight_s + CW'(trk_valid_r[k]);
                end
            end

            assign ret_valid_s = trk_valid_r[MEM_LATENCY-1];
            assign ret_pc_s    = trk_pc_r[MEM_LATENCY-1];
        end
    endgenerate

    // Fetch PC: reset vector, redirect target, or advance by one pair per issue.
    always_ff @(posedge idclk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (gwe) begin
            if (redirect_valid) begin
                pc_r <= redirect_pc;
            end else if (issue_s) begin
                pc_r <= pc_r + 16'd2;
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge idclk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (gwe) begin
            if (redirect_valid) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + (AW+1)'(1);
                    2'b01:   count_r <= count_r - (AW+1)'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // FIFO storage; the credit rule guarantees the written slot is free.
    always_ff @(posedge idclk) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r] <= ret_pc_s;
            fifo_i1_r[wr_ptr_r] <= i1data;
            fifo_i2_r[wr_ptr_r] <= i2data;
        end
    end

    // Memory request and decode-side outputs.
    always_comb begin
        i1re      = issue_s;
        i2re      = issue_s;
        i1addr    = pc_r;
        i2addr    = pc_r + 16'd1;
        out_valid = (count_r != '0) & ~redirect_valid;
        out_pc    = fifo_pc_r[rd_ptr_r];
        out_insn1 = fifo_i1_r[rd_ptr_r];
        out_insn2 = fifo_i2_r[rd_ptr_r];
    end

endmodule

// File: tb/tb_lc4_insn_fetch_unit.sv
// Scoreboard bench for lc4_insn_fetch_unit: three instances (LAT0/D4, LAT8/D4, LAT8/D16)
// share stimulus; each has its own memory model and expected-pair queue.
module tb_lc4_insn_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        gwe;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_ready;

    logic        i1re [3];
    logic        i2re [3];
    logic [15:0] i1addr [3];
    logic [15:0] i2addr [3];
    logic [15:0] i1data [3];
    logic [15:0] i2data [3];
    logic        out_valid [3];
    logic [15:0] out_pc [3];
    logic [15:0] out_insn1 [3];
    logic [15:0] out_insn2 [3];

    logic [15:0] pa1 [1:2][8];
    logic [15:0] pa2 [1:2][8];

    logic [47:0] exp_q0 [$];
    logic [47:0] exp_q1 [$];
    logic [47:0] exp_q2 [$];

    int checks = 0;
    int errors = 0;
    int pop_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            lc4_insn_fetch_unit #(
                .MEM_LATENCY (g == 0 ? 0 : 8),
                .FIFO_DEPTH  (g == 2 ? 16 : 4),
                .RESET_PC    (16'h8200)
            ) u_dut (
                .idclk          (clk),
                .rst            (rst),
                .gwe            (gwe),
                .i1re           (i1re[g]),
                .i2re           (i2re[g]),
                .i1addr         (i1addr[g]),
                .i2addr         (i2addr[g]),
                .i1data         (i1data[g]),
                .i2data         (i2data[g]),
                .redirect_valid (redirect_valid),
                .redirect_pc    (redirect_pc),
                .out_valid      (out_valid[g]),
                .out_ready      (out_ready),
                .out_pc         (out_pc[g]),
                .out_insn1      (out_insn1[g]),
                .out_insn2      (out_insn2[g])
            );
        end
    endgenerate

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[3:0], a[15:4]} ^ 16'h5A3C;
    endfunction

    // Memory image: direct for instance 0, eight gwe-cycle delay line for the others.
    always_comb begin
        i1data[0] = mem_f(i1addr[0]);
        i2data[0] = mem_f(i2addr[0]);
        for (int d = 1; d < 3; d++) begin
            i1data[d] = mem_f(pa1[d][7]);
            i2data[d] = mem_f(pa2[d][7]);
        end
    end

    always @(posedge clk) begin
        if (gwe) begin
            for (int d = 1; d < 3; d++) begin
                pa1[d][0] <= i1addr[d];
                pa2[d][0] <= i2addr[d];
                for (int k = 1; k < 8; k++) begin
                    pa1[d][k] <= pa1[d][k-1];
                    pa2[d][k] <= pa2[d][k-1];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flush_all();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
    endtask

    task automatic expect_run(input logic [15:0] start, input int n);
        logic [15:0] pc;
        logic [47:0] v;
        pc = start;
        for (int i = 0; i < n; i++) begin
            v = {pc, mem_f(pc), mem_f(pc + 16'd1)};
            exp_q0.push_back(v);
            exp_q1.push_back(v);
            exp_q2.push_back(v);
            pc = pc + 16'd2;
        end
    endtask

    task automatic sb_pop(input int d, output logic ok, output logic [47:0] v);
        ok = 1'b0;
        v  = '0;
        case (d)
            0: if (exp_q0.size() > 0) begin ok = 1'b1; v = exp_q0.pop_front(); end
            1: if (exp_q1.size() > 0) begin ok = 1'b1; v = exp_q1.pop_front(); end
            2: if (exp_q2.size() > 0) begin ok = 1'b1; v = exp_q2.pop_front(); end
            default: ok = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head is compared with the next expected pair.
    always @(negedge clk) begin
        logic        ok;
        logic [47:0] e;
        for (int d = 0; d < 3; d++) begin
            if (!rst && redirect_valid) begin
                chk($sformatf("redirect_out_valid[%0d]", d), 16'(out_valid[d]), 16'd0);
            end else if (!rst && gwe && out_valid[d] && out_ready) begin
                pop_cnt[d]++;
                sb_pop(d, ok, e);
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow[%0d]: got out_pc %h expected no output", d, out_pc[d]);
                end else begin
                    chk($sformatf("sb_pc[%0d]", d), out_pc[d], e[47:32]);
                    chk($sformatf("sb_insn1[%0d]", d), out_insn1[d], e[31:16]);
                    chk($sformatf("sb_insn2[%0d]", d), out_insn2[d], e[15:0]);
                end
            end
        end
    end

    initial begin
        int          icnt [3];
        int          base0;
        logic [15:0] saved [3];

        rst = 1'b1; gwe = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000; out_ready = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), 16'(out_valid[d]), 16'd0);
            chk($sformatf("rst_i1re[%0d]", d), 16'(i1re[d]), 16'd0);
        end

        // Test 1: post-reset fetch stream
        flush_all();
        expect_run(16'h8200, 64);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("t1_i1re[%0d]", d), 16'(i1re[d]), 16'd1);
            chk($sformatf("t1_i2re[%0d]", d), 16'(i2re[d]), 16'd1);
            chk($sformatf("t1_i1addr[%0d]", d), i1addr[d], 16'h8200);
            chk($sformatf("t1_i2addr[%0d]", d), i2addr[d], 16'h8201);
        end
        tick();
        chk("t1_out_valid", 16'(out_valid[0]), 16'd1);
        chk("t1_out_pc0", out_pc[0], 16'h8200);
        chk("t1_insn1", out_insn1[0], 16'h521C);
        chk("t1_insn2", out_insn2[0], 16'h421C);
        tick();
        chk("t1_out_pc1", out_pc[0], 16'h8202);
        tick();
        chk("t1_out_pc2", out_pc[0], 16'h8204);
        for (int i = 0; i < 20; i++) tick();

        // Test 2: credit limit with decode stalled
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h3000;
        flush_all();
        expect_run(16'h3000, 64);
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("t2_redir_i1re[%0d]", d), 16'(i1re[d]), 16'd0);
        tick();
        redirect_valid = 1'b0;
        icnt = '{0, 0, 0};
        for (int c = 0; c < 20; c++) begin
            #1;
            for (int d = 0; d < 3; d++) if (i1re[d]) icnt[d]++;
            tick();
        end
        chk("t2_issues_d0", 16'(icnt[0]), 16'd4);
        chk("t2_issues_d1", 16'(icnt[1]), 16'd4);
        chk("t2_issues_d2", 16'(icnt[2]), 16'd16);
        chk("t2_stalled_i1re", 16'(i1re[1]), 16'd0);
        chk("t2_head_valid", 16'(out_valid[1]), 16'd1);
        chk("t2_head_pc", out_pc[1], 16'h3000);
        out_ready = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t2_resume_i1re[%0d]", d), 16'(i1re[d]), 16'd1);
            chk($sformatf("t2_resume_addr[%0d]", d), i1addr[d], 16'h3008);
        end
        for (int i = 0; i < 30; i++) tick();

        // Test 3: redirect with work both buffered and in flight
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h4000;
        flush_all();
        expect_run(16'h4000, 64);
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t3_buffered_d1", 16'(out_valid[1]), 16'd1);
        chk("t3_buffered_d2", 16'(out_valid[2]), 16'd1);
        redirect_valid = 1'b1; redirect_pc = 16'h0100; out_ready = 1'b1;
        flush_all();
        expect_run(16'h0100, 64);
        tick();
        redirect_valid = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("t3_after_redir_valid[%0d]", d), 16'(out_valid[d]), 16'd0);
        for (int i = 0; i < 15; i++) begin
            if (out_valid[2]) break;
            tick();
        end
        chk("t3_wait_valid", 16'(out_valid[2]), 16'd1);
        chk("t3_first_pc", out_pc[2], 16'h0100);
        for (int i = 0; i < 20; i++) tick();

        // Test 4: gwe toggling under load
        redirect_valid = 1'b1; redirect_pc = 16'h5000;
        flush_all();
        expect_run(16'h5000, 64);
        tick();
        redirect_valid = 1'b0;
        base0 = pop_cnt[0];
        for (int i = 0; i < 40; i++) begin
            gwe = (i % 2 == 0);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (!gwe) begin
                    chk($sformatf("t4_frozen_i1re[%0d]", d), 16'(i1re[d]), 16'd0);
                    saved[d] = i1addr[d];
                end else if (i > 0) begin
                    chk($sformatf("t4_pc_held[%0d]", d), i1addr[d], saved[d]);
                end
            end
            tick();
        end
        gwe = 1'b1;
        chk("t4_pops_d0", 16'(pop_cnt[0] - base0), 16'd19);

        // Test 5: address wrap at the top of memory
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        flush_all();
        expect_run(16'hFFFE, 64);
        tick();
        redirect_valid = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("t5_i1re[%0d]", d), 16'(i1re[d]), 16'd1);
            chk($sformatf("t5_i1addr[%0d]", d), i1addr[d], 16'hFFFE);
            chk($sformatf("t5_i2addr[%0d]", d), i2addr[d], 16'hFFFF);
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("t5_wrap_i1addr[%0d]", d), i1addr[d], 16'h0000);
            chk($sformatf("t5_wrap_i2addr[%0d]", d), i2addr[d], 16'h0001);
        end
        chk("t5_out_pc", out_pc[0], 16'hFFFE);
        chk("t5_insn2", out_insn2[0], 16'hA5C3);
        tick();
        chk("t5_out_pc_wrap", out_pc[0], 16'h0000);
        chk("t5_insn1_wrap", out_insn1[0], 16'h5A3C);
        for (int i = 0; i < 20; i++) tick();

        // Test 6: reset with requests in flight
        rst = 1'b1;
        flush_all();
        expect_run(16'h8200, 64);
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t6_quiet_d1_c%0d", k), 16'(out_valid[1]), 16'd0);
            chk($sformatf("t6_quiet_d2_c%0d", k), 16'(out_valid[2]), 16'd0);
            tick();
        end
        chk("t6_valid_d1", 16'(out_valid[1]), 16'd1);
        chk("t6_pc_d1", out_pc[1], 16'h8200);
        chk("t6_valid_d2", 16'(out_valid[2]), 16'd1);
        chk("t6_pc_d2", out_pc[2], 16'h8200);
        for (int i = 0; i < 20; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
